// File: rtl/seven_seg_encoder_if.sv
// Pin bundle between the timer counters and the HEX display back-end.
// The master drives the counts and mode; the slave returns the registered segment patterns.
interface seven_seg_encoder_if;
  logic [7:0] LSBBinary;
  logic [7:0] MSBBinary;
  logic       ModeSel;
  logic       disp_end;
  logic [6:0] HexMSBH;
  logic [6:0] HexMSBL;
  logic [6:0] HexLSBH;
  logic [6:0] HexLSBL;

  modport master (
    output LSBBinary, MSBBinary, ModeSel, disp_end,
    input  HexMSBH, HexMSBL, HexLSBH, HexLSBL
  );

  modport slave (
    input  LSBBinary, MSBBinary, ModeSel, disp_end,
    output HexMSBH, HexMSBL, HexLSBH, HexLSBL
  );
endinterface

// File: rtl/seven_seg_encoder.sv
// Converts two 8-bit counts into four registered active-low 7-segment patterns (a = bit0).
// Counts above 99 saturate to 99; countdown mode can replace the digits with " End".
module seven_seg_encoder (
  input logic                Clock,
  input logic                Reset,
  seven_seg_encoder_if.slave bus
);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegN     = 7'b0101011;
  localparam logic [6:0] SegD     = 7'b0100001;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // Saturate to 99, then double-dabble into {tens, units}.
  function automatic logic [7:0] to_bcd(input logic [7:0] value);
    logic [6:0]  sat;
    logic [14:0] sr;
    sat = (value > 8'd99) ? 7'd99 : value[6:0];
    sr  = {8'd0, sat};
    for (int i = 0; i < 7; i++) begin
      if (sr[10:7] >= 4'd5) sr[10:7] = sr[10:7] + 4'd3;
      if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
      sr = sr << 1;
    end
    return sr[14:7];
  endfunction

  logic [7:0] msb_bcd;
  logic [7:0] lsb_bcd;
  logic       show_end;

  logic [6:0] msbh_d, msbl_d, lsbh_d, lsbl_d;
  logic [6:0] msbh_q, msbl_q, lsbh_q, lsbl_q;

  always_comb begin
    msb_bcd  = to_bcd(bus.MSBBinary);
    lsb_bcd  = to_bcd(bus.LSBBinary);
    show_end = bus.ModeSel & bus.disp_end;

    msbh_d = seg_encode(msb_bcd[7:4]);
    msbl_d = seg_encode(msb_bcd[3:0]);
    lsbh_d = seg_encode(lsb_bcd[7:4]);
    lsbl_d = seg_encode(lsb_bcd[3:0]);

    if (show_end) begin
      msbh_d = SegBlank;
      msbl_d = SegE;
      lsbh_d = SegN;
      lsbl_d = SegD;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      msbh_q <= SegBlank;
      msbl_q <= SegBlank;
      lsbh_q <= SegBlank;
      lsbl_q <= SegBlank;
    end else begin
      msbh_q <= msbh_d;
      msbl_q <= msbl_d;
      lsbh_q <= lsbh_d;
      lsbl_q <= lsbl_d;
    end
  end

  assign bus.HexMSBH = msbh_q;
  assign bus.HexMSBL = msbl_q;
  assign bus.HexLSBH = lsbh_q;
  assign bus.HexLSBL = lsbl_q;

endmodule

// File: tb/tb_seven_seg_encoder.sv
// Directed-vector bench for seven_seg_encoder with hand-tabulated segment patterns.
module tb_seven_seg_encoder;

  logic Clock;
  logic Reset;
  int   n_vec;
  int   n_err;

  seven_seg_encoder_if bus ();

  seven_seg_encoder dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [6:0] Blk = 7'b1111111;
  localparam logic [6:0] PE  = 7'b0000110;
  localparam logic [6:0] PN  = 7'b0101011;
  localparam logic [6:0] PD  = 7'b0100001;

  logic [6:0] seg [10];
  initial begin
    seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100; seg[3] = 7'b0110000;
    seg[4] = 7'b0011001; seg[5] = 7'b0010010; seg[6] = 7'b0000010; seg[7] = 7'b1111000;
    seg[8] = 7'b0000000; seg[9] = 7'b0010000;
  end

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [6:0] mh, input logic [6:0] ml,
                        input logic [6:0] lh, input logic [6:0] ll);
    check({tag, ".MSBH"}, bus.HexMSBH, mh);
    check({tag, ".MSBL"}, bus.HexMSBL, ml);
    check({tag, ".LSBH"}, bus.HexLSBH, lh);
    check({tag, ".LSBL"}, bus.HexLSBL, ll);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] lsb, input logic [7:0] msb, input logic mode,
                       input logic dend);
    bus.LSBBinary = lsb;
    bus.MSBBinary = msb;
    bus.ModeSel   = mode;
    bus.disp_end  = dend;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    drive(8'd37, 8'd200, 1'b1, 1'b1);
    #2;

    // Reset held for two edges with arbitrary inputs.
    tick();
    check4("rst0", Blk, Blk, Blk, Blk);
    tick();
    check4("rst1", Blk, Blk, Blk, Blk);

    Reset = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check4("zero", seg[0], seg[0], seg[0], seg[0]);

    // Stopwatch sweep; 12 must be "12".
    for (int i = 0; i < 16; i++) begin
      drive(8'(i), 8'd0, 1'b0, 1'b0);
      tick();
      check4($sformatf("sw%0d", i), seg[0], seg[0], seg[i / 10], seg[i % 10]);
    end
    check("sw12.LSBH_const", bus.HexLSBH, 7'b1111001);

    // Countdown without end flag.
    for (int i = 0; i < 16; i++) begin
      drive(8'(i), 8'd2, 1'b1, 1'b0);
      tick();
      check4($sformatf("cd%0d", i), 7'b1000000, 7'b0100100, seg[i / 10], seg[i % 10]);
    end

    // End message ignores the counts.
    for (int i = 0; i < 16; i++) begin
      drive(8'(i), 8'd2, 1'b1, 1'b1);
      tick();
      check4($sformatf("end%0d", i), Blk, PE, PN, PD);
    end

    // disp_end ignored in stopwatch mode.
    drive(8'd59, 8'd99, 1'b0, 1'b1);
    tick();
    check4("9959", seg[9], seg[9], seg[5], seg[9]);

    drive(8'd200, 8'd100, 1'b0, 1'b1);
    tick();
    check4("sat", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

    drive(8'd255, 8'd99, 1'b1, 1'b0);
    tick();
    check4("sat255", seg[9], seg[9], seg[9], seg[9]);

    drive(8'd5, 8'd100, 1'b0, 1'b0);
    tick();
    check4("lead0", seg[9], seg[9], seg[0], seg[5]);

    // Outputs must not move without a clock edge.
    drive(8'd47, 8'd31, 1'b0, 1'b0);
    #2;
    check4("nocomb", seg[9], seg[9], seg[0], seg[5]);
    tick();
    check4("3147", seg[3], seg[1], seg[4], seg[7]);

    // Reset mid-sweep while showing End.
    drive(8'd3, 8'd2, 1'b1, 1'b1);
    tick();
    check4("end_pre", Blk, PE, PN, PD);
    drive(8'd4, 8'd2, 1'b1, 1'b1);
    Reset = 1'b1;
    tick();
    check4("rst_mid", Blk, Blk, Blk, Blk);
    Reset = 1'b0;
    drive(8'd7, 8'd42, 1'b1, 1'b0);
    tick();
    check4("post_rst", seg[4], seg[2], seg[0], seg[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_encoder.md
Name: seven_seg_encoder

Overview:
- Display back-end of the two-mode timer: converts two 8-bit binary counts (MSB pair = minutes, LSB pair = seconds) into four registered 7-segment digit patterns for the board HEX displays.
- ModeSel selects stopwatch (0) or countdown (1) mode. In countdown mode, disp_end replaces the digits with an "End" message.
- Sits between the timer counter logic and the HEX display pins.

Parameters:
- none (segment encoding and saturation limit are fixed).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- LSBBinary  input  8  low-pair value (seconds), unsigned binary
- MSBBinary  input  8  high-pair value (minutes), unsigned binary
- ModeSel  input  1  0 = stopwatch mode, 1 = countdown mode
- disp_end  input  1  end-of-countdown flag; honoured only when ModeSel=1
- HexMSBH  output  7  tens digit of MSBBinary
- HexMSBL  output  7  units digit of MSBBinary
- HexLSBH  output  7  tens digit of LSBBinary
- HexLSBL  output  7  units digit of LSBBinary

Behaviour:
- Segment format: active-low, bit0 = a, bit1 = b, ..., bit6 = g.
- Digit patterns [6:0]:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Special patterns [6:0]: blank = 1111111, E = 0000110, n = 0101011, d = 0100001.
- All four outputs are registered. Inputs are sampled on the rising edge of Clock, and outputs reflect them after exactly 1 cycle. There is no combinational path from inputs to outputs.
- Reset=1 at a clock edge forces all four outputs to blank (1111111). Reset takes priority over all other inputs. Normal display resumes on the first edge after Reset is deasserted.
- Conversion: each 8-bit value is converted independently to two BCD digits (tens, units).
  - Values 0..99 map exactly.
  - Values 100..255 saturate to 99 (both digits show 9).
  - No leading-zero blanking: 5 displays as "05".
- ModeSel=0: digits are displayed per the conversion rules; disp_end is ignored.
- ModeSel=1, disp_end=0: identical digit display to ModeSel=0.
- ModeSel=1, disp_end=1: outputs are HexMSBH = blank, HexMSBL = E, HexLSBH = n, HexLSBL = d, regardless of LSBBinary/MSBBinary.
- Mode, flag and value changes take effect 1 cycle after the edge at which they are sampled. No other state is held.

Test Plan:
- Reset=1 for 2 cycles with arbitrary inputs -> all four outputs = 1111111. After deassert, with LSB=0, MSB=0, ModeSel=0 -> all four outputs = 1000000 one cycle later.
- ModeSel=0, MSB=0, sweep LSB 0..15 (one value per cycle) -> HexLSBH/HexLSBL follow "00".."15" with 1-cycle latency; e.g. LSB=12 gives HexLSBH = 1111001, HexLSBL = 0100100; HexMSBH/HexMSBL stay 1000000.
- ModeSel=1, disp_end=0, MSB=2, sweep LSB 0..15 -> same LSB digits as the previous scenario; HexMSBH = 1000000, HexMSBL = 0100100.
- ModeSel=1, disp_end=1, MSB=2, sweep LSB 0..15 -> outputs constant blank/E/n/d (1111111, 0000110, 0101011, 0100001) for all LSB values.
- ModeSel=0, disp_end=1, LSB=59, MSB=99 -> "9959" displayed (disp_end ignored). Then LSB=200, MSB=100 -> all digits 0010000.
- Assert Reset mid-sweep while the "End" message is shown -> all outputs blank on the next edge. After release -> outputs follow the current inputs after 1 cycle.
